// File: rtl/enc_quad_gen_pkg.sv
// Shared constants for the quadrature encoder generator: register offsets, FSM states, helpers.
package enc_quad_gen_pkg;

    localparam logic [3:0]  ADDR_MAIN      = 4'h4;
    localparam logic [3:0]  OFF_GEN_CTRL   = 4'hC;
    localparam logic [3:0]  OFF_GEN_PERIOD = 4'hD;
    localparam logic [3:0]  OFF_GEN_STEPS  = 4'hE;
    localparam logic [3:0]  OFF_GEN_POS    = 4'hF;
    localparam logic [23:0] GEN_POS_RESET  = 24'h800000;

    typedef enum logic {
        GEN_IDLE = 1'b0,
        GEN_RUN  = 1'b1
    } gen_state_e;

    // Periods below 2 would make every cycle a step; clamp so A/B stay well-formed.
    function automatic logic [23:0] period_eff(input logic [23:0] period);
        return (period < 24'd2) ? 24'd2 : period;
    endfunction

    // Phase 0..3 -> {A, B} = 00, 10, 11, 01 (Gray sequence).
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        return {phase[1] ^ phase[0], phase[1]};
    endfunction

endpackage

// File: rtl/enc_step_timer.sv
// Step interval timer: counts sysclk cycles and strobes once per effective period,
// picking up a new period only at a step boundary or on load.
module enc_step_timer
    import enc_quad_gen_pkg::*;
(
    input  logic        sysclk,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [23:0] period,
    output logic        step
);

    logic [23:0] timer_q, timer_d;
    logic [23:0] period_q, period_d;

    assign step = run && !load && (timer_q == period_q - 24'd1);

    always_comb begin
        timer_d  = timer_q;
        period_d = period_q;
        if (load) begin
            timer_d  = '0;
            period_d = period_eff(period);
        end else if (!run) begin
            timer_d = '0;
        end else if (step) begin
            timer_d  = '0;
            period_d = period_eff(period);
        end else begin
            timer_d = timer_q + 24'd1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            timer_q  <= '0;
            period_q <= 24'd2;
        end else begin
            timer_q  <= timer_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/enc_quad_gen.sv
// Quadrature encoder signal generator with register-file control of period, direction and count.
// Optional index output enabled by defining ENC_GEN_INDEX_EN.
module enc_quad_gen
    import enc_quad_gen_pkg::*;
#(
    parameter logic [3:0]  CHAN       = 4'd1,
    parameter logic [23:0] DEF_PERIOD = 24'd1000,
    parameter int unsigned IDX_BITS   = 12
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    output logic        enc_a,
    output logic        enc_b,
    output logic        enc_i,
    output logic        busy,
    output logic        done
);

    gen_state_e  state_q, state_d;
    logic [23:0] period_q, period_d;
    logic [23:0] steps_q, steps_d;
    logic [23:0] pos_q, pos_d;
    logic [23:0] remaining_q, remaining_d;
    logic        dir_q, dir_d;
    logic        dir_run_q, dir_run_d;
    logic        cont_q, cont_d;
    logic [1:0]  phase_q, phase_d;
    logic        done_q, done_d;
    logic        enc_a_q, enc_b_q;
    logic [1:0]  ab_d;

    logic wr_hit, ctrl_wr, start_req, stop_req, step;

    assign wr_hit    = reg_wen && (reg_waddr[15:12] == ADDR_MAIN) && (reg_waddr[7:4] == CHAN);
    assign ctrl_wr   = wr_hit && (reg_waddr[3:0] == OFF_GEN_CTRL);
    assign stop_req  = ctrl_wr && reg_wdata[1];
    assign start_req = ctrl_wr && reg_wdata[0] && !reg_wdata[1];

    enc_step_timer u_timer (
        .sysclk (sysclk),
        .reset  (reset),
        .run    (state_q == GEN_RUN),
        .load   (start_req),
        .period (period_q),
        .step   (step)
    );

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        steps_d     = steps_q;
        pos_d       = pos_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        dir_run_d   = dir_run_q;
        cont_d      = cont_q;
        phase_d     = phase_q;
        done_d      = 1'b0;

        if (wr_hit) begin
            case (reg_waddr[3:0])
                OFF_GEN_CTRL:   dir_d    = reg_wdata[2];
                OFF_GEN_PERIOD: period_d = reg_wdata[23:0];
                OFF_GEN_STEPS:  steps_d  = reg_wdata[23:0];
                OFF_GEN_POS:    if (state_q == GEN_IDLE) pos_d = reg_wdata[23:0];
                default: ;
            endcase
        end

        if (stop_req) begin
            state_d = GEN_IDLE;
        end else if (start_req) begin
            state_d     = GEN_RUN;
            remaining_d = steps_q;
            cont_d      = (steps_q == '0);
            dir_run_d   = reg_wdata[2];
        end else if (step) begin
            phase_d   = dir_run_q ? phase_q + 2'd1 : phase_q - 2'd1;
            pos_d     = dir_run_q ? pos_q + 24'd1 : pos_q - 24'd1;
            // Direction written mid-interval applies from the following step.
            dir_run_d = dir_q;
            if (!cont_q) begin
                remaining_d = remaining_q - 24'd1;
                if (remaining_q == 24'd1) begin
                    state_d = GEN_IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    assign ab_d = phase_to_ab(phase_d);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= GEN_IDLE;
            period_q    <= DEF_PERIOD;
            steps_q     <= '0;
            pos_q       <= GEN_POS_RESET;
            remaining_q <= '0;
            dir_q       <= 1'b1;
            dir_run_q   <= 1'b1;
            cont_q      <= 1'b0;
            phase_q     <= 2'd0;
            done_q      <= 1'b0;
            enc_a_q     <= 1'b0;
            enc_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            steps_q     <= steps_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            dir_run_q   <= dir_run_d;
            cont_q      <= cont_d;
            phase_q     <= phase_d;
            done_q      <= done_d;
            enc_a_q     <= ab_d[1];
            enc_b_q     <= ab_d[0];
        end
    end

`ifdef ENC_GEN_INDEX_EN
    logic enc_i_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            enc_i_q <= 1'b0;
        end else begin
            enc_i_q <= (phase_d == 2'd0) && (pos_d[IDX_BITS-1:0] == '0);
        end
    end

    assign enc_i = enc_i_q;
`else
    logic unused_idx_bits;
    assign unused_idx_bits = ^IDX_BITS;
    assign enc_i = 1'b0;
`endif

    assign enc_a = enc_a_q;
    assign enc_b = enc_b_q;
    assign busy  = (state_q == GEN_RUN);
    assign done  = done_q;

    always_comb begin
        reg_rdata = 32'd0;
        if (reg_raddr[7:4] == CHAN) begin
            case (reg_raddr[3:0])
                OFF_GEN_CTRL:   reg_rdata = {29'd0, dir_q, busy, 1'b0};
                OFF_GEN_PERIOD: reg_rdata = {8'd0, period_q};
                OFF_GEN_STEPS:  reg_rdata = {8'd0, (state_q == GEN_RUN) ? remaining_q : steps_q};
                OFF_GEN_POS:    reg_rdata = {8'd0, pos_q};
                default:        reg_rdata = 32'd0;
            endcase
        end
    end

    logic unused_bus;
    assign unused_bus = ^{reg_wdata[31:24], reg_raddr[15:8], reg_waddr[11:8]};

endmodule

// File: tb/tb_enc_quad_gen.sv
// Self-checking bench for enc_quad_gen: expected edges come from a step-time schedule model.
module tb_enc_quad_gen;
    import enc_quad_gen_pkg::*;

    localparam logic [3:0] CHAN  = 4'd1;
    localparam int         NEVER = 1 << 30;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] reg_waddr = '0;
    logic [31:0] reg_wdata = '0;
    logic        reg_wen = 1'b0;
    logic [15:0] reg_raddr = '0;
    logic [31:0] reg_rdata;
    logic        enc_a, enc_b, enc_i, busy, done;

    int          n_vec = 0;
    int          n_err = 0;
    int          m_phase = 0;
    logic [23:0] m_pos = 24'h800000;
    logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 sysclk = ~sysclk;

    enc_quad_gen #(.CHAN(CHAN), .DEF_PERIOD(24'd1000), .IDX_BITS(2)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .reg_wen   (reg_wen),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .enc_i     (enc_i),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic exp_index(input int phase, input logic [23:0] pos);
`ifdef ENC_GEN_INDEX_EN
        return (phase == 0) && (pos[1:0] == 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic bus_idle();
        reg_wen   = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
    endtask

    task automatic drive(input logic [3:0] chan, input logic [3:0] off, input logic [31:0] data);
        reg_wen   = 1'b1;
        reg_waddr = {ADDR_MAIN, 4'h0, chan, off};
        reg_wdata = data;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        @(negedge sysclk);
        drive(CHAN, off, data);
        @(negedge sysclk);
        bus_idle();
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] v);
        reg_raddr = {ADDR_MAIN, 4'h0, CHAN, off};
        #1;
        v = reg_rdata;
    endtask

    // One run: start at edge 0; optional period write, stop, restart and STEPS write are
    // driven at cycle *_k (sampled at edge *_k+1). Step times are scheduled up front.
    task automatic run_case(input int p0, input int n0, input bit d, input int horizon,
                            input int chg_k, input int p1, input int stop_k,
                            input int rs_k, input int sw_k, input int sw_v);
        int          times[$];
        int          stop_e, rs_e, chg_e, sw_e, done_e, b, per, rem, n2, t;
        int          cnt, seg2, seg_n, seg_c, ph, phase0;
        bit          cont, restarted;
        logic [23:0] pos0, epos;
        logic [31:0] v, exp_steps;
        logic [1:0]  ab;

        wr(OFF_GEN_PERIOD, 32'(p0));
        wr(OFF_GEN_STEPS, 32'(n0));
        stop_e = (stop_k < 0) ? NEVER : stop_k + 1;
        rs_e   = (rs_k < 0) ? NEVER : rs_k + 1;
        chg_e  = (chg_k < 0) ? NEVER : chg_k + 1;
        sw_e   = (sw_k < 0) ? NEVER : sw_k + 1;
        n2     = (sw_e < rs_e) ? sw_v : n0;
        b = 0; per = eff(p0); rem = n0; cont = (n0 == 0); done_e = NEVER; restarted = 0;
        while (1) begin
            t = b + per;
            if (!restarted && t >= rs_e) begin
                restarted = 1; b = rs_e; rem = n2; cont = (n2 == 0);
                per = eff((chg_e < rs_e) ? p1 : p0);
                continue;
            end
            if (t >= stop_e || t > horizon) break;
            times.push_back(t);
            b = t;
            per = eff((chg_e < b) ? p1 : p0);
            if (!cont) begin
                rem--;
                if (rem == 0) begin
                    done_e = t;
                    break;
                end
            end
        end

        phase0 = m_phase;
        pos0   = m_pos;
        @(negedge sysclk);
        drive(CHAN, OFF_GEN_CTRL, {29'd0, d, 2'b01});
        for (int k = 0; k <= horizon; k++) begin
            @(negedge sysclk);
            bus_idle();
            if (k == chg_k) drive(CHAN, OFF_GEN_PERIOD, 32'(p1));
            if (k == stop_k) drive(CHAN, OFF_GEN_CTRL, {29'd0, d, 2'b10});
            if (k == rs_k) drive(CHAN, OFF_GEN_CTRL, {29'd0, d, 2'b01});
            if (k == sw_k) drive(CHAN, OFF_GEN_STEPS, 32'(sw_v));
            cnt = 0; seg2 = 0;
            foreach (times[j]) if (times[j] <= k) begin
                cnt++;
                if (times[j] >= rs_e) seg2++;
            end
            ph   = (phase0 + (d ? cnt : 3 * cnt)) % 4;
            epos = d ? pos0 + 24'(cnt) : pos0 - 24'(cnt);
            ab   = ab_tab[ph];
            chk("enc_a", 32'(enc_a), 32'(ab[1]));
            chk("enc_b", 32'(enc_b), 32'(ab[0]));
            chk("enc_i", 32'(enc_i), 32'(exp_index(ph, epos)));
            chk("busy", 32'(busy), 32'(k < stop_e && k < done_e));
            chk("done", 32'(done), 32'(k == done_e));
            if (k % 2 == 0) begin
                rd(OFF_GEN_POS, v);
                chk("pos", v, {8'd0, epos});
            end else begin
                if (k < stop_e && k < done_e) begin
                    seg_n = (k >= rs_e) ? n2 : n0;
                    seg_c = (k >= rs_e) ? seg2 : cnt;
                    exp_steps = (seg_n == 0) ? 32'd0 : 32'(seg_n - seg_c);
                end else begin
                    exp_steps = (sw_e <= k) ? 32'(sw_v) : 32'(n0);
                end
                rd(OFF_GEN_STEPS, v);
                chk("steps_rd", v, exp_steps);
            end
        end
        cnt = times.size();
        m_phase = (phase0 + (d ? cnt : 3 * cnt)) % 4;
        m_pos   = d ? pos0 + 24'(cnt) : pos0 - 24'(cnt);
    endtask

    initial begin
        logic [31:0] v;
        logic [23:0] np;
        int          w;

        #1 reset = 1'b0;
        repeat (2) @(negedge sysclk);
        chk("rst_a", 32'(enc_a), 32'd0);
        chk("rst_b", 32'(enc_b), 32'd0);
        chk("rst_i", 32'(enc_i), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rd(OFF_GEN_POS, v);    chk("rst_pos", v, 32'h0080_0000);
        rd(OFF_GEN_PERIOD, v); chk("rst_period", v, 32'd1000);
        rd(OFF_GEN_STEPS, v);  chk("rst_steps", v, 32'd0);
        rd(OFF_GEN_CTRL, v);   chk("rst_ctrl", v, 32'h4);
        @(negedge sysclk);
        reset = 1'b1;

        // A write to another channel must be ignored.
        @(negedge sysclk);
        drive(4'd2, OFF_GEN_PERIOD, 32'd7);
        @(negedge sysclk);
        bus_idle();
        rd(OFF_GEN_PERIOD, v); chk("chan_decode", v, 32'd1000);

        run_case(4, 8, 1'b1, 36, -1, 0, -1, -1, -1, 0);
        rd(OFF_GEN_POS, v); chk("pos_after_8", v, 32'h0080_0008);

        wr(OFF_GEN_POS, 32'd2);
        m_pos = 24'd2;
        run_case(3, 5, 1'b0, 20, -1, 0, -1, -1, -1, 0);
        rd(OFF_GEN_POS, v); chk("pos_wrap_down", v, 32'h00FF_FFFD);

        run_case(0, 3, 1'b1, 10, -1, 0, -1, -1, -1, 0);
        run_case(1, 3, 1'b0, 10, -1, 0, -1, -1, -1, 0);

        // Continuous, period change mid-interval, then stop.
        run_case(10, 0, 1'b1, 30, 4, 5, 22, -1, -1, 0);

        // Restart with remaining=3 after STEPS was rewritten to 6.
        run_case(4, 5, 1'b1, 40, -1, 0, -1, 10, 9, 6);

        wr(OFF_GEN_CTRL, 32'h7);
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            chk("ss_busy", 32'(busy), 32'd0);
            chk("ss_a", 32'(enc_a), 32'(ab_tab[m_phase][1]));
            rd(OFF_GEN_POS, v); chk("ss_pos", v, {8'd0, m_pos});
        end

        for (int r = 0; r < 6; r++) begin
            int p0, n0;
            bit d;
            if ($urandom_range(0, 1) == 1) begin
                np = (r % 2 == 1) ? 24'hFFFFFE : 24'($urandom);
                wr(OFF_GEN_POS, {8'd0, np});
                m_pos = np;
            end
            p0 = int'($urandom_range(0, 6));
            n0 = int'($urandom_range(1, 6));
            d  = 1'($urandom_range(0, 1));
            run_case(p0, n0, d, eff(p0) * n0 + 3, -1, 0, -1, -1, -1, 0);
        end

        // Asynchronous reset mid-run.
        wr(OFF_GEN_PERIOD, 32'd2);
        wr(OFF_GEN_STEPS, 32'd0);
        wr(OFF_GEN_CTRL, 32'h5);
        w = 0;
        while (enc_a !== 1'b1 && w < 20) begin
            @(negedge sysclk);
            w++;
        end
        chk("pre_reset_a", 32'(enc_a), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_a", 32'(enc_a), 32'd0);
        chk("arst_b", 32'(enc_b), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        rd(OFF_GEN_POS, v); chk("arst_pos", v, 32'h0080_0000);
        @(negedge sysclk);
        rd(OFF_GEN_PERIOD, v); chk("arst_period", v, 32'd1000);
        rd(OFF_GEN_CTRL, v);   chk("arst_ctrl", v, 32'h4);
        reset = 1'b1;
        m_phase = 0;
        m_pos   = 24'h800000;
        run_case(4, 2, 1'b1, 10, -1, 0, -1, -1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enc_quad_gen.md
Name: enc_quad_gen

Overview:
- Quadrature encoder signal generator: the transmit-side counterpart of the encoder decode/count path.
- Drives enc_a/enc_b with a programmable step period, direction and step count.
- Used for board self-test and loopback of the encoder inputs, and for driving an emulated axis.
- Programmed through the same register-file write/read bus as the other board blocks, one channel per instance.

Parameters:
- CHAN, 4'd1, channel nibble matched against reg_waddr[7:4] / reg_raddr[7:4]
- DEF_PERIOD, 24'd1000, reset value of PERIOD register (sysclk cycles per transition)
- IDX_BITS, 12, index pulse spacing exponent (counts = 2^IDX_BITS); used only with ENC_GEN_INDEX_EN

Ports:
- sysclk  in  1  global clock
- reset  in  1  global reset, asynchronous, active-low
- reg_waddr  in  16  register write address
- reg_wdata  in  32  register write data
- reg_wen  in  1  write enable
- reg_raddr  in  16  register read address
- reg_rdata  out  32  read data (combinational)
- enc_a  out  1  quadrature A (registered)
- enc_b  out  1  quadrature B (registered)
- enc_i  out  1  index pulse (registered)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse on count completion

Behaviour:
- Write decode: a write is accepted when reg_wen=1, reg_waddr[15:12]==ADDR_MAIN and reg_waddr[7:4]==CHAN; the register is selected by reg_waddr[3:0].
- Registers:
  - GEN_CTRL: bit0 start (pulse, not stored), bit1 stop (pulse), bit2 dir (1 = A leads, count up).
  - GEN_PERIOD [23:0].
  - GEN_STEPS [23:0]: transitions to emit; 0 = continuous.
  - GEN_POS [23:0]: emitted position.
- Reset values: enc_a=enc_b=enc_i=0, phase=0, busy=0, done=0, state IDLE, PERIOD=DEF_PERIOD, STEPS=0, dir=1, POS=24'h800000, timer=0.
- Phase encoding: phase 0..3 maps to (A,B) = 00, 10, 11, 01. A step with dir=1 does phase+1 mod 4 and POS+1; a step with dir=0 does phase-1 mod 4 and POS-1. POS wraps modulo 2^24.
- State machine has two states, IDLE and RUN.
- IDLE:
  - start moves to RUN; timer=0; remaining=STEPS; dir, period and mode are latched.
  - Effective period is max(PERIOD, 2).
- RUN:
  - timer counts up each cycle.
  - When timer==period_eff-1: a step is applied (outputs update on that edge), timer returns to 0, and remaining decrements unless in continuous mode.
  - First edge occurs exactly period_eff cycles after the cycle in which the start write is sampled.
  - When the step that brings remaining to 0 occurs: next state is IDLE, busy falls and done pulses high for 1 cycle, all aligned with that final output edge.
- Writes during RUN:
  - PERIOD and dir writes go to the register and take effect at the next step boundary (period reloaded when timer returns to 0).
  - STEPS writes do not alter remaining.
  - POS writes are ignored during RUN and accepted in IDLE.
- Start while in RUN restarts the run: remaining reloaded, timer=0, phase/POS kept.
- Stop in any state goes to IDLE next cycle with no done pulse; outputs hold their current level.
- Start and stop in the same write: stop wins.
- Reset asserted mid-run: all state returns to reset values immediately (asynchronously).
- Read map, when reg_raddr[7:4]==CHAN:
  - GEN_CTRL returns {29'd0, dir, busy, 1'b0}.
  - GEN_PERIOD returns {8'd0, PERIOD}.
  - GEN_STEPS returns {8'd0, remaining} in RUN and {8'd0, STEPS} in IDLE.
  - GEN_POS returns {8'd0, POS}.
  - Any other address returns 32'd0.

Optional Feature:
- Macro ENC_GEN_INDEX_EN.
- Defined: enc_i is registered high during any cycle where phase==0 and POS[IDX_BITS-1:0]==0, with the same timing as enc_a/enc_b.
- Undefined: enc_i is tied 0 and no index logic is generated.

Decomposition:
- Shared constants include gains new offsets OFF_GEN_CTRL=4'hC, OFF_GEN_PERIOD=4'hD, OFF_GEN_STEPS=4'hE, OFF_GEN_POS=4'hF, plus state encodings GEN_IDLE/GEN_RUN. ADDR_MAIN is reused.
- One natural sub-module, enc_step_timer: period counter with step strobe and period reload at the boundary.
- Top level holds the register file, FSM, phase and POS.

Test Plan:
- Reset: PERIOD=4, STEPS=8, dir=1, start -> first A rise 4 cycles after start; sequence 00→10→11→01→00 ×2; POS=0x800008; done pulses once coincident with the 8th edge; busy low after.
- dir=0, PERIOD=3, STEPS=5 from POS=0x000002 -> phases step down; POS wraps to 0xFFFFFD; edges every 3 cycles.
- PERIOD=0 and PERIOD=1 -> edges every 2 cycles (clamp).
- STEPS=0 continuous run, PERIOD=10: write PERIOD=5 mid-interval -> current interval remains 10 and subsequent intervals are 5; then stop -> IDLE next cycle, outputs hold, no done.
- Start+stop in one write while IDLE -> stays IDLE. Start while RUN with remaining=3 and STEPS=6 -> remaining=6, timer restarts.
- Async reset asserted mid-run -> enc_a/enc_b=0, busy=0, POS=0x800000 without waiting for a sysclk edge. With ENC_GEN_INDEX_EN and IDX_BITS=2: enc_i high whenever POS%4==0 with phase 0.
